mem_stage_dcache: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache in the MEM stage, between EX_MEM and MEM_WB.
- Serves word loads and stores from the pipeline and drives BUSYWAIT, which freezes the pipeline registers including MEM_WB.
- READDATA feeds the MEM_WB data input.
- On a miss it runs a block-level handshake with data memory.

---
 rtl/mem_stage_dcache.sv | 133 +++++++++++++
 tb/tb_mem_stage_dcache.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_dcache.sv
// MEM-stage data cache: direct-mapped, write-back, write-allocate, 4-word blocks.
// Loads hit combinationally, stores hit on the next edge, and misses run a
// block-level writeback/fetch handshake with data memory while stalling the pipe.
module mem_stage_dcache #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 32 - INDEX_BITS - 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           READ,
  input  logic           WRITE,
  input  logic [31:0]    ADDRESS,
  input  logic [31:0]    WRITEDATA,
  output logic [31:0]    READDATA,
  output logic           BUSYWAIT,
  output logic           MEM_READ,
  output logic           MEM_WRITE,
  output logic [27:0]    MEM_ADDRESS,
  output logic [127:0]   MEM_WRITEDATA,
  input  logic [127:0]   MEM_READDATA,
  input  logic           MEM_BUSYWAIT
);

  localparam int SETS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    UPDATE
  } state_t;

  state_t                r_state;
  logic [SETS-1:0]       r_valid;
  logic [SETS-1:0]       r_dirty;
  logic [TAG_BITS-1:0]   r_tag  [SETS];
  logic [127:0]          r_data [SETS];

  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [1:0]            w_offset;
  logic [6:0]            w_bitBase;
  logic                  w_req;
  logic                  w_hit;
  logic                  w_victimDirty;
  logic [127:0]          w_line;
  logic [31:0]           w_word;
  logic                  w_unused;

  // Byte-within-word bits never matter for word accesses.
  assign w_unused      = ^ADDRESS[1:0];

  assign w_index       = ADDRESS[3+INDEX_BITS:4];
  assign w_tag         = ADDRESS[31:4+INDEX_BITS];
  assign w_offset      = ADDRESS[3:2];
  assign w_bitBase     = {w_offset, 5'd0};
  assign w_req         = READ | WRITE;
  assign w_hit         = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_victimDirty = r_valid[w_index] && r_dirty[w_index];

  // Select the addressed word out of the indexed line for same-cycle load data.
  always_comb begin
    w_line = r_data[w_index];
    w_word = w_line[w_bitBase +: 32];
  end

  // Outputs are forced low while reset is held so an abandoned miss releases the pipe at once.
  assign READDATA = (RESET && r_state == IDLE && w_req && w_hit) ? w_word : 32'd0;
  assign BUSYWAIT = RESET && ((r_state != IDLE) || (w_req && !w_hit));

  // Miss controller plus valid/dirty bookkeeping; memory handshake outputs are registered.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state       <= IDLE;
      r_valid       <= '0;
      r_dirty       <= '0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= 28'd0;
      MEM_WRITEDATA <= 128'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !w_hit) begin
            if (w_victimDirty) begin
              r_state       <= WRITEBACK;
              MEM_WRITE     <= 1'b1;
              MEM_ADDRESS   <= {r_tag[w_index], w_index};
              MEM_WRITEDATA <= r_data[w_index];
            end else begin
              r_state     <= FETCH;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= ADDRESS[31:4];
            end
          end else if (WRITE && w_hit) begin
            r_dirty[w_index] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            r_state     <= FETCH;
            MEM_WRITE   <= 1'b0;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= ADDRESS[31:4];
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            r_state  <= UPDATE;
            MEM_READ <= 1'b0;
          end
        end
        UPDATE: begin
          r_state          <= IDLE;
          r_valid[w_index] <= 1'b1;
          r_dirty[w_index] <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays keep their contents across reset; only the valid bits gate their use.
  always_ff @(posedge CLK) begin
    if (r_state == UPDATE) begin
      r_data[w_index] <= MEM_READDATA;
      r_tag[w_index]  <= w_tag;
    end else if (r_state == IDLE && WRITE && w_hit) begin
      r_data[w_index][w_bitBase +: 32] <= WRITEDATA;
    end
  end

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Bench for mem_stage_dcache: a latency-programmable block memory, plus a reference
// model holding the architectural word contents and which block each set holds.
module tb_mem_stage_dcache;

  logic         CLK;
  logic         RESET;
  logic         READ;
  logic         WRITE;
  logic [31:0]  ADDRESS;
  logic [31:0]  WRITEDATA;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int vectors;
  int miscompares;
  int memLatency;
  int memCount;

  logic [127:0] backing [logic [27:0]];
  logic [31:0]  refMem  [logic [29:0]];
  bit           mVal   [8];
  bit           mDirty [8];
  logic [24:0]  mTag   [8];

  mem_stage_dcache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Power-on contents of data memory; word address 0x10 (byte 0x40) holds 0xDEADBEEF.
  function automatic logic [31:0] initWord(logic [29:0] wa);
    if (wa == 30'h10) return 32'hDEADBEEF;
    return {2'b01, wa} ^ 32'h0F0F_0000;
  endfunction

  function automatic logic [127:0] readBlock(logic [27:0] ba);
    if (backing.exists(ba)) return backing[ba];
    return {initWord({ba, 2'd3}), initWord({ba, 2'd2}), initWord({ba, 2'd1}), initWord({ba, 2'd0})};
  endfunction

  function automatic logic [31:0] memWord(logic [29:0] wa);
    logic [127:0] b;
    b = readBlock(wa[29:2]);
    return b[{wa[1:0], 5'd0} +: 32];
  endfunction

  function automatic logic [31:0] refRead(logic [29:0] wa);
    if (refMem.exists(wa)) return refMem[wa];
    return initWord(wa);
  endfunction

  // Data memory: completes a request after memLatency cycles, dropping busy for that one cycle.
  always @(negedge CLK) begin
    if (RESET === 1'b1 && (MEM_READ === 1'b1 || MEM_WRITE === 1'b1)) begin
      memCount = memCount + 1;
      if (memCount >= memLatency) begin
        if (MEM_WRITE === 1'b1) backing[MEM_ADDRESS] = MEM_WRITEDATA;
        else MEM_READDATA = readBlock(MEM_ADDRESS);
        MEM_BUSYWAIT = 1'b0;
        memCount     = 0;
      end else begin
        MEM_BUSYWAIT = 1'b1;
      end
    end else begin
      memCount     = 0;
      MEM_BUSYWAIT = 1'b1;
    end
  end

  // Reference model: what the access should cost and return, then record its effect.
  task automatic predict(input logic [31:0] addr, input bit isWr, input logic [31:0] wdata,
                         input int lat, output int expStalls, output logic [31:0] expRdata,
                         output bit expWb, output logic [27:0] expWbAddr, output logic [127:0] expWbData);
    logic [2:0]  idx;
    logic [24:0] tg;
    logic [29:0] wa;
    bit          hit;
    idx = addr[6:4];
    tg  = addr[31:7];
    wa  = addr[31:2];
    hit = mVal[idx] && (mTag[idx] == tg);
    expWb     = !hit && mVal[idx] && mDirty[idx];
    expWbAddr = {mTag[idx], idx};
    expWbData = '0;
    if (mVal[idx])
      expWbData = {refRead({mTag[idx], idx, 2'd3}), refRead({mTag[idx], idx, 2'd2}),
                   refRead({mTag[idx], idx, 2'd1}), refRead({mTag[idx], idx, 2'd0})};
    expStalls = hit ? 0 : (expWb ? 2 * lat + 2 : lat + 2);
    if (isWr) refMem[wa] = wdata;
    expRdata = refRead(wa);
    if (!hit) begin
      mVal[idx]   = 1'b1;
      mTag[idx]   = tg;
      mDirty[idx] = 1'b0;
    end
    if (isWr) mDirty[idx] = 1'b1;
  endtask

  // Reset wipes the cache, so unwritten-back stores are lost; the architectural view falls back to memory.
  task automatic modelReset();
    for (int i = 0; i < 8; i++) begin
      mVal[i]   = 1'b0;
      mDirty[i] = 1'b0;
    end
    foreach (refMem[k]) refMem[k] = memWord(k);
  endtask

  // Drive one request from a falling edge and observe it until the stall clears (bounded).
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               output int stalls, output logic firstBusy, output logic [31:0] rdata,
                               output bit sawBoth, output bit sawWb, output logic [27:0] wbAddr,
                               output logic [127:0] wbData, output bit sawFetch, output logic [27:0] fAddr);
    sawBoth  = 1'b0;
    sawWb    = 1'b0;
    sawFetch = 1'b0;
    wbAddr   = '0;
    wbData   = '0;
    fAddr    = '0;
    READ      = rd;
    WRITE     = wr;
    ADDRESS   = addr;
    WRITEDATA = wdata;
    #1;
    firstBusy = BUSYWAIT;
    stalls    = 0;
    while (BUSYWAIT === 1'b1 && stalls < 400) begin
      stalls++;
      @(negedge CLK);
      #1;
      if (MEM_READ === 1'b1 && MEM_WRITE === 1'b1) sawBoth = 1'b1;
      if (MEM_WRITE === 1'b1 && !sawWb) begin
        sawWb  = 1'b1;
        wbAddr = MEM_ADDRESS;
        wbData = MEM_WRITEDATA;
      end
      if (MEM_READ === 1'b1 && !sawFetch) begin
        sawFetch = 1'b1;
        fAddr    = MEM_ADDRESS;
      end
    end
    rdata = READDATA;
    @(negedge CLK);
    READ  = 1'b0;
    WRITE = 1'b0;
  endtask

  // Everything idle and zero while reset is held.
  task automatic test_reset();
    RESET = 1'b0;
    READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    @(negedge CLK);
    #1;
    vectors++; if (BUSYWAIT !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busywait: got %b expected 0", BUSYWAIT); end
    vectors++; if (MEM_READ !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_read: got %b expected 0", MEM_READ); end
    vectors++; if (MEM_WRITE !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_write: got %b expected 0", MEM_WRITE); end
    vectors++; if (MEM_ADDRESS !== 28'd0) begin miscompares++; $display("[TB] FAIL reset_mem_address: got %h expected 0", MEM_ADDRESS); end
    vectors++; if (MEM_WRITEDATA !== 128'd0) begin miscompares++; $display("[TB] FAIL reset_mem_writedata: got %h expected 0", MEM_WRITEDATA); end
    vectors++; if (READDATA !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_readdata: got %h expected 0", READDATA); end
    @(negedge CLK);
    RESET = 1'b1;
    modelReset();
    @(negedge CLK);
  endtask

  // Cold read miss at 0x40 with latency 5, then a hit on the neighbouring word.
  task automatic test_read_miss_and_hit();
    int st, es; logic fb; logic [31:0] rd, er; bit sb, sw, sf, ew; logic [27:0] wa, fa, ewa; logic [127:0] wd, ewd;
    memLatency = 5;
    predict(32'h40, 1'b0, 32'd0, memLatency, es, er, ew, ewa, ewd);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, st, fb, rd, sb, sw, wa, wd, sf, fa);
    vectors++; if (fb !== 1'b1) begin miscompares++; $display("[TB] FAIL miss_busy_same_cycle: got %b expected 1", fb); end
    vectors++; if (st !== 7 || st !== es) begin miscompares++; $display("[TB] FAIL miss_stall_cycles: got %0d expected 7", st); end
    vectors++; if (sf !== 1'b1 || fa !== 28'h4) begin miscompares++; $display("[TB] FAIL miss_fetch_addr: got %b/%h expected 1/0000004", sf, fa); end
    vectors++; if (sw !== 1'b0 || sb !== 1'b0) begin miscompares++; $display("[TB] FAIL miss_no_writeback: got wb=%b both=%b expected 0/0", sw, sb); end
    vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL miss_readdata: got %h expected deadbeef", rd); end
    predict(32'h44, 1'b0, 32'd0, memLatency, es, er, ew, ewa, ewd);
    applyStimulus(1'b1, 1'b0, 32'h44, 32'd0, st, fb, rd, sb, sw, wa, wd, sf, fa);
    vectors++; if (fb !== 1'b0 || st !== 0) begin miscompares++; $display("[TB] FAIL hit_no_stall: got busy=%b stalls=%0d expected 0/0", fb, st); end
    vectors++; if (rd !== er) begin miscompares++; $display("[TB] FAIL hit_readdata: got %h expected %h", rd, er); end
  endtask

  // Store hit then load the same word back, neither stalling.
  task automatic test_write_hit();
    int st, es; logic fb; logic [31:0] rd, er; bit sb, sw, sf, ew; logic [27:0] wa, fa, ewa; logic [127:0] wd, ewd;
    predict(32'h40, 1'b1, 32'h12345678, memLatency, es, er, ew, ewa, ewd);
    applyStimulus(1'b0, 1'b1, 32'h40, 32'h12345678, st, fb, rd, sb, sw, wa, wd, sf, fa);
    vectors++; if (fb !== 1'b0 || st !== 0) begin miscompares++; $display("[TB] FAIL write_hit_stall: got busy=%b stalls=%0d expected 0/0", fb, st); end
    predict(32'h40, 1'b0, 32'd0, memLatency, es, er, ew, ewa, ewd);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, st, fb, rd, sb, sw, wa, wd, sf, fa);
    vectors++; if (st !== 0) begin miscompares++; $display("[TB] FAIL readback_stall: got %0d expected 0", st); end
    vectors++; if (rd !== 32'h12345678) begin miscompares++; $display("[TB] FAIL readback_data: got %h expected 12345678", rd); end
  endtask

  // Conflict on set 4 forces a writeback of the dirty line before the fetch.
  task automatic test_dirty_evict();
    int st, es; logic fb; logic [31:0] rd, er; bit sb, sw, sf, ew; logic [27:0] wa, fa, ewa; logic [127:0] wd, ewd;
    predict(32'hC0, 1'b0, 32'd0, memLatency, es, er, ew, ewa, ewd);
    applyStimulus(1'b1, 1'b0, 32'hC0, 32'd0, st, fb, rd, sb, sw, wa, wd, sf, fa);
    vectors++; if (sw !== 1'b1 || wa !== 28'h4) begin miscompares++; $display("[TB] FAIL evict_wb_addr: got %b/%h expected 1/0000004", sw, wa); end
    vectors++; if (wd[31:0] !== 32'h12345678 || wd !== ewd) begin miscompares++; $display("[TB] FAIL evict_wb_data: got %h expected %h", wd, ewd); end
    vectors++; if (sf !== 1'b1 || fa !== 28'hC) begin miscompares++; $display("[TB] FAIL evict_fetch_addr: got %b/%h expected 1/000000c", sf, fa); end
    vectors++; if (st !== 12 || st !== es) begin miscompares++; $display("[TB] FAIL evict_stall_cycles: got %0d expected 12", st); end
    vectors++; if (rd !== er || sb !== 1'b0) begin miscompares++; $display("[TB] FAIL evict_readdata: got %h both=%b expected %h/0", rd, sb, er); end
    predict(32'h40, 1'b0, 32'd0, memLatency, es, er, ew, ewa, ewd);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, st, fb, rd, sb, sw, wa, wd, sf, fa);
    vectors++; if (sw !== 1'b0 || st !== 7) begin miscompares++; $display("[TB] FAIL clean_after_fetch: got wb=%b stalls=%0d expected 0/7", sw, st); end
    vectors++; if (rd !== 32'h12345678) begin miscompares++; $display("[TB] FAIL writeback_roundtrip: got %h expected 12345678", rd); end
  endtask

  // Reset asserted mid-fetch must release the pipe immediately and invalidate everything.
  task automatic test_reset_during_fetch();
    int st, es, waitCycles; logic fb; logic [31:0] rd, er; bit sb, sw, sf, ew; logic [27:0] wa, fa, ewa; logic [127:0] wd, ewd;
    memLatency = 5;
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 32'h100; WRITEDATA = '0;
    waitCycles = 0;
    do begin
      @(negedge CLK);
      #1;
      waitCycles++;
    end while (MEM_READ !== 1'b1 && waitCycles < 20);
    vectors++; if (MEM_READ !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_fetch_started: got %b expected 1", MEM_READ); end
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    vectors++; if (BUSYWAIT !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busywait: got %b expected 0", BUSYWAIT); end
    vectors++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_mem_req: got %b/%b expected 0/0", MEM_READ, MEM_WRITE); end
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    modelReset();
    @(negedge CLK);
    predict(32'h44, 1'b0, 32'd0, memLatency, es, er, ew, ewa, ewd);
    applyStimulus(1'b1, 1'b0, 32'h44, 32'd0, st, fb, rd, sb, sw, wa, wd, sf, fa);
    vectors++; if (fb !== 1'b1 || st !== 7) begin miscompares++; $display("[TB] FAIL post_reset_miss: got busy=%b stalls=%0d expected 1/7", fb, st); end
    vectors++; if (rd !== er) begin miscompares++; $display("[TB] FAIL post_reset_data: got %h expected %h", rd, er); end
  endtask

  // READ and WRITE together on a miss behave as a write-allocate store.
  task automatic test_read_write_both();
    int st, es; logic fb; logic [31:0] rd, er, wv; bit sb, sw, sf, ew; logic [27:0] wa, fa, ewa; logic [127:0] wd, ewd;
    memLatency = 3;
    wv = $urandom;
    predict(32'h204, 1'b1, wv, memLatency, es, er, ew, ewa, ewd);
    applyStimulus(1'b1, 1'b1, 32'h204, wv, st, fb, rd, sb, sw, wa, wd, sf, fa);
    vectors++; if (st !== 5 || sf !== 1'b1 || fa !== 28'h20) begin miscompares++; $display("[TB] FAIL both_miss: got stalls=%0d fetch=%b/%h expected 5/1/0000020", st, sf, fa); end
    predict(32'h204, 1'b0, 32'd0, memLatency, es, er, ew, ewa, ewd);
    applyStimulus(1'b1, 1'b0, 32'h204, 32'd0, st, fb, rd, sb, sw, wa, wd, sf, fa);
    vectors++; if (st !== 0 || rd !== wv) begin miscompares++; $display("[TB] FAIL both_merge: got stalls=%0d data=%h expected 0/%h", st, rd, wv); end
    predict(32'h404, 1'b0, 32'd0, memLatency, es, er, ew, ewa, ewd);
    applyStimulus(1'b1, 1'b0, 32'h404, 32'd0, st, fb, rd, sb, sw, wa, wd, sf, fa);
    vectors++; if (sw !== 1'b1 || wa !== 28'h20 || wd[63:32] !== wv) begin miscompares++; $display("[TB] FAIL both_dirty: got wb=%b addr=%h word1=%h expected 1/0000020/%h", sw, wa, wd[63:32], wv); end
  endtask

  // Random back-to-back loads/stores over a few conflicting sets with varying memory latency.
  task automatic test_random();
    int st, es, op; logic fb; logic [31:0] rd, er, addr, wv; bit sb, sw, sf, ew, isWr; logic [27:0] wa, fa, ewa; logic [127:0] wd, ewd;
    for (int n = 0; n < 80; n++) begin
      memLatency = $urandom_range(1, 4);
      op   = $urandom_range(0, 2);
      isWr = (op != 0);
      addr = {23'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      wv   = $urandom;
      predict(addr, isWr, wv, memLatency, es, er, ew, ewa, ewd);
      applyStimulus(op != 1, op != 0, addr, wv, st, fb, rd, sb, sw, wa, wd, sf, fa);
      vectors++; if (st !== es) begin miscompares++; $display("[TB] FAIL rand_stalls @%h: got %0d expected %0d", addr, st, es); end
      vectors++; if (sb !== 1'b0) begin miscompares++; $display("[TB] FAIL rand_both_req @%h: got 1 expected 0", addr); end
      vectors++; if (sw !== ew) begin miscompares++; $display("[TB] FAIL rand_wb_seen @%h: got %b expected %b", addr, sw, ew); end
      if (ew) begin
        vectors++; if (wa !== ewa || wd !== ewd) begin miscompares++; $display("[TB] FAIL rand_wb_block @%h: got %h/%h expected %h/%h", addr, wa, wd, ewa, ewd); end
      end
      if (es != 0) begin
        vectors++; if (sf !== 1'b1 || fa !== addr[31:4]) begin miscompares++; $display("[TB] FAIL rand_fetch @%h: got %b/%h expected 1/%h", addr, sf, fa, addr[31:4]); end
      end
      if (op == 0) begin
        vectors++; if (rd !== er) begin miscompares++; $display("[TB] FAIL rand_readdata @%h: got %h expected %h", addr, rd, er); end
      end
    end
  endtask

  // Final tally line.
  task automatic checkOutput();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  // Test sequence.
  initial begin
    vectors      = 0;
    miscompares  = 0;
    memLatency   = 5;
    memCount     = 0;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = '0;
    for (int i = 0; i < 8; i++) mTag[i] = '0;
    test_reset();
    test_read_miss_and_hit();
    test_write_hit();
    test_dirty_evict();
    test_reset_during_fetch();
    test_read_write_both();
    test_random();
    checkOutput();
    $finish;
  end

endmodule
